ddr_block_bridge: RTL
=====================

Name: ddr_block_bridge

Overview:
- Bridges the cache/CPU block interface to the MIG 7-series user interface (app_*), running entirely in the MIG ui_clk domain.
- Moves one BLOCK_W-bit block per request as BEATS = BLOCK_W/MIG_DW consecutive MIG commands, with independent command, write-data and read-data handshakes.
- Holds the last transferred block so repeated reads of it complete without a DRAM access.
- Replaces the single-beat, level-driven controller with a request/response FSM.

Parameters:
- BLOCK_W, 256, cache block width in bits; a multiple of MIG_DW.
- MIG_DW, 128, MIG app data width (4:1 mode, 16-bit DQ).
- ADDR_W, 30, request word address width (4-byte aligned).
- MIG_AW, 27, app_addr width.
- DQ_W, 16, DRAM data-bus width; one app_addr unit = DQ_W/8 bytes.
- HOLD_LAST, 1, 1 enables the last-block read hit path.

Ports:
- clk  in  1  ui_clk from the MIG.
- rst_n  in  1  asynchronous reset, active low.
- req_valid  in  1  request present.
- req_write  in  1  1 = write block, 0 = read block.
- req_addr  in  ADDR_W  word address; low log2(BLOCK_W/32) bits are ignored.
- req_wdata  in  BLOCK_W  write block.
- req_ready  out  1  request accepted on this edge when high together with req_valid.
- resp_valid  out  1  one-cycle pulse: read data valid, or write fully handed to the MIG.
- resp_rdata  out  BLOCK_W  read block; held until the next response.
- app_addr  out  MIG_AW
- app_cmd  out  3  000 = write, 001 = read.
- app_en  out  1
- app_rdy  in  1
- app_wdf_data  out  MIG_DW
- app_wdf_wren  out  1
- app_wdf_end  out  1
- app_wdf_mask  out  MIG_DW/8
- app_wdf_rdy  in  1
- app_rd_data  in  MIG_DW
- app_rd_data_valid  in  1
- init_calib_complete  in  1

Behaviour:
- Reset values: req_ready=0, resp_valid=0, resp_rdata=0, app_en=0, app_wdf_wren=0, app_wdf_end=0, app_cmd=001, app_addr=0, app_wdf_data=0; counters 0; last-block valid=0.
- app_wdf_mask is always 0.
- Reset asserted mid-transfer aborts everything and returns to IDLE. MIG commands already issued are not recalled.
- States: IDLE, WR, RD_CMD, RD_DATA, RESP.
- IDLE:
  - req_ready = init_calib_complete.
  - On accept, latch the address (offset cleared), write flag and wdata.
  - Hit: if HOLD_LAST, it is a read, and the block index equals the last-block tag with valid set, go to RESP. The hit response appears 1 cycle after accept.
  - Otherwise go to WR or RD_CMD.
- Address of beat i: (block_byte_addr + i*MIG_DW/8)/(DQ_W/8), truncated to MIG_AW bits (wraps modulo 2^MIG_AW). With defaults, word 0x0000_0028 gives beats 0x50 and 0x58.
- WR:
  - Separate counters cmd_cnt and wdf_cnt, each 0..BEATS.
  - app_en=1 while cmd_cnt<BEATS; cmd_cnt increments on app_en&app_rdy.
  - app_wdf_wren=app_wdf_end=1 while wdf_cnt<BEATS; wdf_cnt increments on wren&app_wdf_rdy.
  - app_wdf_data = beat wdf_cnt, the low slice first.
  - Write data may lead or trail its command. No ordering constraint beyond MIG rules.
  - When both counters reach BEATS, go to RESP.
- RD_CMD: issue BEATS read commands with the same cmd_cnt rule, then go to RD_DATA.
- Read data capture:
  - rd_cnt counts app_rd_data_valid beats; beat rd_cnt goes into slice rd_cnt of resp_rdata.
  - Returning data is accepted in RD_CMD as well (data may arrive before the last command).
  - When rd_cnt reaches BEATS, go to RESP.
  - app_rd_data_valid in any other state is ignored.
- RESP:
  - resp_valid=1 for exactly one cycle, then IDLE.
  - req_ready is 0 in RESP, so back-to-back throughput is one request per 2 cycles minimum.
- Last-block update:
  - A completed read sets tag := block index, valid := 1.
  - A completed write sets tag := block index, stores the write block as resp_rdata, valid := 1 (write-through).
  - A write to a different block simply retags.
- init_calib_complete falling mid-transfer is not handled (stay in state). It only gates acceptance.
- Handshake: app_en, app_addr and app_cmd are held stable until app_rdy. Same rule for app_wdf_* until app_wdf_rdy.

Decomposition:
- Package ddr_bridge_pkg holds:
  - state encoding;
  - CMD_WRITE=3'b000, CMD_READ=3'b001;
  - helper function beat_addr(block_byte_addr, beat).
- BEATS and the offset width are derived localparams.
- One sub-module: ddr_beat_counter, a parametrised 0..BEATS counter with enable, clear and done. It is instantiated three times (cmd, wdf, rd).

Test Plan:
- Reset + calib: hold init_calib_complete=0 for 20 cycles with req_valid=1 -> req_ready stays 0 and no app_en. Raise it -> accepted next edge.
- Write word 0x28, wdata {128'hA.., 128'h5..}, app_rdy and app_wdf_rdy always 1 -> app_addr 0x50 then 0x58, cmd 000, wdf data low slice then high slice, resp_valid 1 cycle after the last beat.
- Write with app_wdf_rdy delayed 5 cycles and app_rdy toggling -> addresses and data held stable while stalled, exactly 2 commands and 2 wdf writes, single resp_valid.
- Read word 0x100 with MIG returning 2 beats 10 cycles later, the first beat arriving before the second command is accepted -> resp_rdata = {beat1, beat0}, one resp_valid.
- Re-read word 0x100 (HOLD_LAST=1) -> resp_valid 1 cycle after accept, no app_en. With HOLD_LAST=0 -> a full MIG read.
- Assert rst_n=0 during RD_DATA -> all outputs return to reset values immediately and the stale read beat is ignored. The next read completes correctly.

Source files
------------

// File: rtl/ddr_bridge_pkg.sv
// ============================================================================
// ddr_bridge_pkg : shared types, MIG command codes and beat address helper
// Revision: 1.0
// ============================================================================
`default_nettype none

package ddr_bridge_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR      = 3'd1,
    S_RD_CMD  = 3'd2,
    S_RD_DATA = 3'd3,
    S_RESP    = 3'd4
  } state_e;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  // Byte address of beat N expressed in app_addr units; the caller truncates.
  function automatic logic [63:0] beat_addr(input logic [63:0] block_byte_addr,
                                            input logic [31:0] beat,
                                            input logic [31:0] beat_bytes,
                                            input logic [31:0] unit_bytes);
    logic [63:0] byte_addr;
    byte_addr = block_byte_addr + 64'(beat) * 64'(beat_bytes);
    return byte_addr / 64'(unit_bytes);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ddr_beat_counter.sv
// ============================================================================
// ddr_beat_counter : saturating 0..MAX beat counter with clear and done flags
// Revision: 1.0
// ============================================================================
`default_nettype none

module ddr_beat_counter #(
  parameter int MAX = 2,
  localparam int CW = $clog2(MAX + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [CW-1:0] cnt_o,
  output logic          done_o,
  output logic          last_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !done_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign done_o = (cnt_q == CW'(MAX));
  // High when the current enabled step is the one that reaches MAX.
  assign last_o = en_i && (cnt_q == CW'(MAX - 1));

endmodule

`default_nettype wire

// File: rtl/ddr_block_bridge.sv
// ============================================================================
// ddr_block_bridge : cache block request/response to MIG 7-series app_* bridge
// Revision: 1.0
// ============================================================================
`default_nettype none

module ddr_block_bridge
  import ddr_bridge_pkg::*;
#(
  parameter int BLOCK_W   = 256,
  parameter int MIG_DW    = 128,
  parameter int ADDR_W    = 30,
  parameter int MIG_AW    = 27,
  parameter int DQ_W      = 16,
  parameter int HOLD_LAST = 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_valid_i,
  input  logic                req_write_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [BLOCK_W-1:0]  req_wdata_i,
  output logic                req_ready_o,
  output logic                resp_valid_o,
  output logic [BLOCK_W-1:0]  resp_rdata_o,
  output logic [MIG_AW-1:0]   app_addr_o,
  output logic [2:0]          app_cmd_o,
  output logic                app_en_o,
  input  logic                app_rdy_i,
  output logic [MIG_DW-1:0]   app_wdf_data_o,
  output logic                app_wdf_wren_o,
  output logic                app_wdf_end_o,
  output logic [MIG_DW/8-1:0] app_wdf_mask_o,
  input  logic                app_wdf_rdy_i,
  input  logic [MIG_DW-1:0]   app_rd_data_i,
  input  logic                app_rd_data_valid_i,
  input  logic                init_calib_complete_i
);

  localparam int BEATS = BLOCK_W / MIG_DW;
  localparam int OFF_W = $clog2(BLOCK_W / 32);
  localparam int CW    = $clog2(BEATS + 1);
  localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int TAG_W = ADDR_W - OFF_W;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_W) - 1);

  state_e                       state_q, state_d;
  logic [ADDR_W-1:0]            addr_q, addr_d;
  logic                         write_q, write_d;
  logic [BEATS-1:0][MIG_DW-1:0] wdata_q, wdata_d;
  logic [BEATS-1:0][MIG_DW-1:0] rdata_q, rdata_d;
  logic [TAG_W-1:0]             tag_q, tag_d;
  logic                         tag_vld_q, tag_vld_d;

  logic [CW-1:0] cmd_cnt, wdf_cnt, rd_cnt;
  logic          cmd_done, wdf_done, rd_done;
  logic          cmd_last, wdf_last, rd_last;
  logic          cnt_clr, rd_en, hit;

  assign cnt_clr = (state_q == S_IDLE);
  assign rd_en   = app_rd_data_valid_i && ((state_q == S_RD_CMD) || (state_q == S_RD_DATA));

  ddr_beat_counter #(.MAX(BEATS)) u_cmd_cnt (
    .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(cnt_clr), .en_i(app_en_o && app_rdy_i),
    .cnt_o(cmd_cnt), .done_o(cmd_done), .last_o(cmd_last)
  );

  ddr_beat_counter #(.MAX(BEATS)) u_wdf_cnt (
    .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(cnt_clr), .en_i(app_wdf_wren_o && app_wdf_rdy_i),
    .cnt_o(wdf_cnt), .done_o(wdf_done), .last_o(wdf_last)
  );

  ddr_beat_counter #(.MAX(BEATS)) u_rd_cnt (
    .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(cnt_clr), .en_i(rd_en),
    .cnt_o(rd_cnt), .done_o(rd_done), .last_o(rd_last)
  );

  // Gated by rst_ni so the port reads 0 while reset is held.
  assign req_ready_o    = rst_ni && (state_q == S_IDLE) && init_calib_complete_i;
  assign resp_valid_o   = (state_q == S_RESP);
  assign resp_rdata_o   = rdata_q;
  assign app_en_o       = ((state_q == S_WR) || (state_q == S_RD_CMD)) && !cmd_done;
  assign app_cmd_o      = write_q ? CMD_WRITE : CMD_READ;
  assign app_addr_o     = MIG_AW'(beat_addr(64'({addr_q, 2'b00}), 32'(cmd_cnt),
                                            32'(MIG_DW / 8), 32'(DQ_W / 8)));
  assign app_wdf_wren_o = (state_q == S_WR) && !wdf_done;
  assign app_wdf_end_o  = app_wdf_wren_o;
  assign app_wdf_data_o = wdata_q[wdf_cnt[IDX_W-1:0]];
  assign app_wdf_mask_o = '0;

  assign hit = (HOLD_LAST != 0) && !req_write_i && tag_vld_q &&
               (tag_q == req_addr_i[ADDR_W-1:OFF_W]);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    tag_d     = tag_q;
    tag_vld_d = tag_vld_q;
    if (rd_en && !rd_done) begin
      rdata_d[rd_cnt[IDX_W-1:0]] = app_rd_data_i;
    end
    case (state_q)
      S_IDLE: begin
        if (req_valid_i && req_ready_o) begin
          addr_d  = req_addr_i & ~OFF_MASK;
          write_d = req_write_i;
          wdata_d = req_wdata_i;
          if (hit)              state_d = S_RESP;
          else if (req_write_i) state_d = S_WR;
          else                  state_d = S_RD_CMD;
        end
      end
      S_WR: begin
        if ((cmd_done || cmd_last) && (wdf_done || wdf_last)) begin
          state_d   = S_RESP;
          rdata_d   = wdata_q;
          tag_d     = addr_q[ADDR_W-1:OFF_W];
          tag_vld_d = 1'b1;
        end
      end
      S_RD_CMD: begin
        if (cmd_done || cmd_last) begin
          state_d = S_RD_DATA;
          if (rd_done || rd_last) begin
            state_d   = S_RESP;
            tag_d     = addr_q[ADDR_W-1:OFF_W];
            tag_vld_d = 1'b1;
          end
        end
      end
      S_RD_DATA: begin
        if (rd_done || rd_last) begin
          state_d   = S_RESP;
          tag_d     = addr_q[ADDR_W-1:OFF_W];
          tag_vld_d = 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      tag_q     <= '0;
      tag_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      tag_q     <= tag_d;
      tag_vld_q <= tag_vld_d;
    end
  end

endmodule

`default_nettype wire
